// File: rtl/seg_scan_ctrl.sv
// Scan controller for an 8-digit multiplexed 7-segment display with a double-buffered frame.
// Optional build macro SEG_SCAN_HEX_DECODE_EN: store hex-decoded glyphs instead of raw segment bytes.
module seg_scan_ctrl #(
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       WR_EN,
  input  logic [2:0] WR_ADDR,
  input  logic [7:0] WR_DATA,
  output logic       WR_READY,
  input  logic       SWAP_REQ,
  output logic       SWAP_DONE,
  output logic       FRAME_TICK,
  output logic [7:0] SEG_OUT,
  output logic [7:0] SEG_SEL
);

  localparam int unsigned MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam int unsigned DIGITS  = 8;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [2:0]       LAST_IDX   = 3'd7;

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic             r_front;
  logic             r_pending;
  logic [7:0]       r_buf [2][DIGITS];

  logic             r_wr_ready;
  logic             r_swap_done;
  logic             r_frame_tick;
  logic [7:0]       r_seg_out;
  logic [7:0]       r_seg_sel;

  logic [0:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_idx_nxt;
  logic             w_front_nxt;
  logic             w_pending_nxt;
  logic             w_tick_nxt;
  logic             w_done_nxt;
  logic [7:0]       w_seg_out_nxt;
  logic [7:0]       w_seg_sel_nxt;
  logic             w_wr_ok;
  logic [7:0]       w_wr_pattern;

`ifdef SEG_SCAN_HEX_DECODE_EN
  // Segment order is {upper, right-upper, right-lower, lower, left-lower, left-upper, center}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'b1111110;
      4'h1:    s = 7'b0110000;
      4'h2:    s = 7'b1101101;
      4'h3:    s = 7'b1111001;
      4'h4:    s = 7'b0110011;
      4'h5:    s = 7'b1011011;
      4'h6:    s = 7'b1011111;
      4'h7:    s = 7'b1110000;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1111011;
      4'hA:    s = 7'b1110111;
      4'hB:    s = 7'b0011111;
      4'hC:    s = 7'b1001110;
      4'hD:    s = 7'b0111101;
      4'hE:    s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  assign w_wr_pattern = {hex_to_seg(WR_DATA[3:0]), WR_DATA[4]};
`else
  assign w_wr_pattern = WR_DATA;
`endif

  // Writes are refused while a swap is outstanding so the back buffer is frozen until it flips.
  assign w_wr_ok = WR_EN && !r_pending;

  // Next-state, swap arbitration and output pre-computation.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_idx_nxt     = r_idx;
    w_front_nxt   = r_front;
    w_tick_nxt    = 1'b0;
    w_done_nxt    = 1'b0;
    w_pending_nxt = r_pending;
    w_seg_out_nxt = 8'h00;
    w_seg_sel_nxt = 8'h00;

    if (!EN) begin
      w_state_nxt = ST_BLANK;
      w_cnt_nxt   = '0;
      w_idx_nxt   = 3'd0;
      if (r_pending) begin
        w_front_nxt = ~r_front;
        w_done_nxt  = 1'b1;
      end
    end else begin
      case (r_state)
        ST_BLANK: begin
          if (r_cnt >= BLANK_LAST) begin
            w_state_nxt = ST_DRIVE;
            w_cnt_nxt   = CNT_ONE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        ST_DRIVE: begin
          if (r_cnt >= DWELL_LAST) begin
            w_state_nxt = ST_BLANK;
            w_cnt_nxt   = CNT_ONE;
            w_idx_nxt   = r_idx + 3'd1;
            // Frame boundary: the only point where an enabled scan may flip buffers.
            if (r_idx == LAST_IDX) begin
              w_tick_nxt = 1'b1;
              if (r_pending) begin
                w_front_nxt = ~r_front;
                w_done_nxt  = 1'b1;
              end
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = '0;
          w_idx_nxt   = 3'd0;
        end
      endcase
    end

    // A request arriving while one is pending (or being applied) merges into it.
    if (w_done_nxt) begin
      w_pending_nxt = 1'b0;
    end else if (SWAP_REQ) begin
      w_pending_nxt = 1'b1;
    end

    if (w_state_nxt == ST_DRIVE) begin
      w_seg_sel_nxt = 8'b1 << w_idx_nxt;
      w_seg_out_nxt = r_buf[w_front_nxt][w_idx_nxt];
    end
  end

  // State, frame buffers and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= ST_BLANK;
      r_cnt        <= '0;
      r_idx        <= 3'd0;
      r_front      <= 1'b0;
      r_pending    <= 1'b0;
      r_wr_ready   <= 1'b1;
      r_swap_done  <= 1'b0;
      r_frame_tick <= 1'b0;
      r_seg_out    <= 8'h00;
      r_seg_sel    <= 8'h00;
      for (int b = 0; b < 2; b++) begin
        for (int d = 0; d < DIGITS; d++) begin
          r_buf[b][d] <= 8'h00;
        end
      end
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_front      <= w_front_nxt;
      r_pending    <= w_pending_nxt;
      r_wr_ready   <= !w_pending_nxt;
      r_swap_done  <= w_done_nxt;
      r_frame_tick <= w_tick_nxt;
      r_seg_out    <= w_seg_out_nxt;
      r_seg_sel    <= w_seg_sel_nxt;
      if (w_wr_ok) begin
        r_buf[~r_front][WR_ADDR] <= w_wr_pattern;
      end
    end
  end

  assign WR_READY   = r_wr_ready;
  assign SWAP_DONE  = r_swap_done;
  assign FRAME_TICK = r_frame_tick;
  assign SEG_OUT    = r_seg_out;
  assign SEG_SEL    = r_seg_sel;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random traffic against a frame-level model.
module tb_seg_scan_ctrl;

  localparam int unsigned DW    = 4;
  localparam int unsigned BL    = 2;
  localparam int          SLOT  = 6;
  localparam int          FRAME = 48;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EN = 1'b0;
  logic       WR_EN = 1'b0;
  logic [2:0] WR_ADDR = 3'd0;
  logic [7:0] WR_DATA = 8'h00;
  logic       SWAP_REQ = 1'b0;
  logic       WR_READY;
  logic       SWAP_DONE;
  logic       FRAME_TICK;
  logic [7:0] SEG_OUT;
  logic [7:0] SEG_SEL;

  always #5 CLK = ~CLK;

  seg_scan_ctrl #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR),
    .WR_DATA(WR_DATA), .WR_READY(WR_READY), .SWAP_REQ(SWAP_REQ),
    .SWAP_DONE(SWAP_DONE), .FRAME_TICK(FRAME_TICK), .SEG_OUT(SEG_OUT),
    .SEG_SEL(SEG_SEL)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: two whole frames that trade places, plus the number of enabled cycles since restart.
  logic [7:0] m_front [8];
  logic [7:0] m_back  [8];
  bit         m_pending;
  int         m_age;
  logic [7:0] e_out, e_sel;
  logic       e_tick, e_done, e_ready;

  function automatic logic [7:0] store_val(input logic [7:0] d);
`ifdef SEG_SCAN_HEX_DECODE_EN
    logic [6:0] g;
    case (d[3:0])
      4'h0: g = 7'b1111110;  4'h1: g = 7'b0110000;
      4'h2: g = 7'b1101101;  4'h3: g = 7'b1111001;
      4'h4: g = 7'b0110011;  4'h5: g = 7'b1011011;
      4'h6: g = 7'b1011111;  4'h7: g = 7'b1110000;
      4'h8: g = 7'b1111111;  4'h9: g = 7'b1111011;
      4'hA: g = 7'b1110111;  4'hB: g = 7'b0011111;
      4'hC: g = 7'b1001110;  4'hD: g = 7'b0111101;
      4'hE: g = 7'b1001111;  default: g = 7'b1000111;
    endcase
    return {g, d[4]};
`else
    return d;
`endif
  endfunction

  function automatic int m_pos();
    return (m_age > 0) ? (m_age - 1) % FRAME : -1;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rst, input bit en, input bit wr, input logic [2:0] a,
                            input logic [7:0] d, input bit swp);
    bit do_swap;
    int p;
    int dig;
    logic [7:0] t;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        m_front[i] = 8'h00;
        m_back[i]  = 8'h00;
      end
      m_pending = 1'b0;
      m_age = 0;
      e_out = 8'h00; e_sel = 8'h00; e_tick = 1'b0; e_done = 1'b0; e_ready = 1'b1;
      return;
    end
    if (wr && !m_pending) m_back[a] = store_val(d);
    e_tick = 1'b0;
    if (en) begin
      m_age++;
      e_tick = (m_age > FRAME) && ((m_age - 1) % FRAME == 0);
      do_swap = e_tick && m_pending;
    end else begin
      m_age = 0;
      do_swap = m_pending;
    end
    if (do_swap) begin
      for (int i = 0; i < 8; i++) begin
        t = m_front[i];
        m_front[i] = m_back[i];
        m_back[i] = t;
      end
      m_pending = 1'b0;
    end else if (swp) begin
      m_pending = 1'b1;
    end
    e_done = do_swap;
    e_ready = !m_pending;
    e_sel = 8'h00;
    e_out = 8'h00;
    if (en) begin
      p = (m_age - 1) % FRAME;
      dig = p / SLOT;
      if (p % SLOT >= int'(BL)) begin
        e_sel = 8'(1) << dig;
        e_out = m_front[dig];
      end
    end
  endtask

  // One clock: drive inputs, advance model on the edge, compare just after it.
  task automatic step(input bit rst, input bit en, input bit wr, input logic [2:0] a,
                      input logic [7:0] d, input bit swp);
    RST = rst; EN = en; WR_EN = wr; WR_ADDR = a; WR_DATA = d; SWAP_REQ = swp;
    @(posedge CLK);
    model_edge(rst, en, wr, a, d, swp);
    #1;
    chk("seg_sel",    SEG_SEL,           e_sel);
    chk("seg_out",    SEG_OUT,           e_out);
    chk("frame_tick", 8'(FRAME_TICK),    8'(e_tick));
    chk("swap_done",  8'(SWAP_DONE),     8'(e_done));
    chk("wr_ready",   8'(WR_READY),      8'(e_ready));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
  endtask

  task automatic wait_pos(input int target);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 3 * FRAME; k++) begin
      if (m_pos() == target) begin
        found = 1'b1;
        break;
      end
      step(1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    end
    chk("wait_pos_reached", 8'(found), 8'd1);
  endtask

  initial begin
    int first_tick;
    int dones;
    bit seen;

    // Reset state.
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    chk("reset_wr_ready", 8'(WR_READY), 8'd1);

    // Free-running scan, empty frame; first tick must land on output cycle 49.
    first_tick = 0;
    for (int c = 1; c <= 100; c++) begin
      step(1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
      if (FRAME_TICK && first_tick == 0) first_tick = c;
    end
    chk("first_tick_cycle", 8'(first_tick), 8'd49);

    // Two writes, the second together with SWAP_REQ; a write during pending is dropped.
    step(1'b0, 1'b1, 1'b1, 3'd0, 8'b01101110, 1'b0);
    step(1'b0, 1'b1, 1'b1, 3'd1, 8'b10011110, 1'b1);
    step(1'b0, 1'b1, 1'b1, 3'd2, 8'hFF, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 3 * FRAME; k++) begin
      step(1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
      if (SWAP_DONE) begin
        chk("done_with_tick", 8'(FRAME_TICK), 8'd1);
        seen = 1'b1;
        break;
      end
    end
    chk("swap_done_seen", 8'(seen), 8'd1);
    idle(FRAME);

    // Triple request within one frame must produce a single swap.
    wait_pos(0);
    dones = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      step(1'b0, 1'b1, 1'b0, 3'd0, 8'h00, (k == 1) || (k == 5) || (k == 9));
      if (SWAP_DONE) dones++;
    end
    chk("triple_req_one_done", 8'(dones), 8'd1);

    // EN dropped in mid-drive of digit 3 with a swap pending.
    wait_pos(0);
    step(1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1);
    wait_pos(3 * SLOT + int'(BL) + 1);
    step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    chk("en_low_sel", SEG_SEL, 8'h00);
    chk("en_low_done", 8'(SWAP_DONE), 8'd1);
    step(1'b0, 1'b0, 1'b1, 3'd4, 8'h5A, 1'b0);
    step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    idle(2);
    chk("restart_blank", SEG_SEL, 8'h00);
    idle(1);
    chk("restart_digit0", SEG_SEL, 8'h01);
    idle(FRAME);

    // Hex-style value on digit 0 (raw or decoded depending on build).
    step(1'b0, 1'b1, 1'b1, 3'd0, 8'h1A, 1'b1);
    idle(2 * FRAME + 8);

    // Random traffic including rare resets and enable drops.
    for (int k = 0; k < 5000; k++) begin
      step($urandom_range(0, 1499) == 0, $urandom_range(0, 59) != 0,
           $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
           8'($urandom_range(0, 255)), $urandom_range(0, 69) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
